// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline definitions: the fetch-stage constants and the
// instruction slot type carried between stage registers.
package otter_pipe_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        valid;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry capture/drain buffer that parks an instruction fetch response
// arriving while decode is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_ir,
  input  logic [31:0] load_pc,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      ir    <= load_ir;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: program counter, instruction-port drive and
// the decode pipeline register, with stall skid and execute redirects.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = otter_pipe_pkg::DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = otter_pipe_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RD,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] DEC_IR,
  output logic [31:0] DEC_PC,
  output logic [31:0] DEC_PC4,
  output logic        DEC_VALID
);
  import otter_pipe_pkg::*;

  logic [31:0] fpc;
  logic [31:0] rpc;
  logic        rvalid;
  logic [31:0] target;
  fetch_slot_t dec;
  logic [31:0] dec_pc4;

  logic [31:0] skid_ir;
  logic [31:0] skid_pc;
  logic        skid_valid;

  assign target    = {REDIRECT_PC[31:2], 2'b00};
  assign IMEM_ADDR = REDIRECT ? target : fpc;
  assign IMEM_RD   = RST & (REDIRECT | ~STALL);

  // Capture only the response issued before the stall began; issue stops
  // during a stall so at most one response ever needs parking.
  fetch_skid_buf u_skid (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (STALL & rvalid & ~skid_valid),
    .drain   (~STALL),
    .flush   (REDIRECT),
    .load_ir (IMEM_DATA),
    .load_pc (rpc),
    .ir      (skid_ir),
    .pc      (skid_pc),
    .valid   (skid_valid)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fpc       <= RESET_VECTOR;
      rpc       <= '0;
      rvalid    <= 1'b0;
      dec.ir    <= NOP_INSTR;
      dec.pc    <= '0;
      dec.valid <= 1'b0;
      dec_pc4   <= 32'd4;
    end else if (REDIRECT) begin
      fpc       <= target + 32'd4;
      rpc       <= target;
      rvalid    <= 1'b1;
      dec.ir    <= NOP_INSTR;
      dec.valid <= 1'b0;
    end else if (STALL) begin
      rvalid <= 1'b0;
    end else begin
      if (skid_valid) begin
        dec.ir    <= skid_ir;
        dec.pc    <= skid_pc;
        dec.valid <= 1'b1;
        dec_pc4   <= skid_pc + 32'd4;
      end else if (rvalid) begin
        dec.ir    <= IMEM_DATA;
        dec.pc    <= rpc;
        dec.valid <= 1'b1;
        dec_pc4   <= rpc + 32'd4;
      end else begin
        dec.ir    <= NOP_INSTR;
        dec.valid <= 1'b0;
      end
      rpc    <= fpc;
      rvalid <= 1'b1;
      fpc    <= fpc + 32'd4;
    end
  end

  assign DEC_IR    = dec.ir;
  assign DEC_PC    = dec.pc;
  assign DEC_PC4   = dec_pc4;
  assign DEC_VALID = dec.valid;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against an abstract stream model.
module tb_otter_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RD;
  logic [31:0] IMEM_DATA;
  logic [31:0] DEC_IR;
  logic [31:0] DEC_PC;
  logic [31:0] DEC_PC4;
  logic        DEC_VALID;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  otter_fetch_stage #(
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_RD     (IMEM_RD),
    .IMEM_DATA   (IMEM_DATA),
    .DEC_IR      (DEC_IR),
    .DEC_PC      (DEC_PC),
    .DEC_PC4     (DEC_PC4),
    .DEC_VALID   (DEC_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0000_0013 | (a << 20);
  endfunction

  // Instruction memory with synchronous one-cycle read latency
  initial IMEM_DATA = '0;
  always @(posedge CLK) if (IMEM_RD) IMEM_DATA <= word({IMEM_ADDR[31:2], 2'b00});

  // Abstract model: the decode stream is consecutive words starting at m_next;
  // m_primed says whether a fetch for m_next is already on its way.
  logic [31:0] m_next;
  logic        m_primed;
  logic        m_valid;
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  logic [31:0] last_addr;
  logic        last_rd;

  task automatic model_reset();
    m_next   = 32'h0;
    m_primed = 1'b0;
    m_valid  = 1'b0;
    m_ir     = NOP;
    m_pc     = 32'h0;
  endtask

  task automatic model_edge(input bit stall, input bit redir, input logic [31:0] tgt);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (redir) begin
      m_valid  = 1'b0;
      m_ir     = NOP;
      m_next   = t;
      m_primed = 1'b1;
    end else if (!stall) begin
      if (m_primed) begin
        m_valid = 1'b1;
        m_pc    = m_next;
        m_ir    = word(m_next);
        m_next  = m_next + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_ir    = NOP;
      end
      m_primed = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [31:0] exp_addr;
    exp_addr = REDIRECT ? {REDIRECT_PC[31:2], 2'b00} : (m_primed ? m_next + 32'd4 : m_next);
    chk("imem_rd", {31'b0, IMEM_RD}, {31'b0, RST & (REDIRECT | ~STALL)});
    if (RST) chk("imem_addr", IMEM_ADDR, exp_addr);
    chk("dec_valid", {31'b0, DEC_VALID}, {31'b0, m_valid});
    chk("dec_ir", DEC_IR, m_ir);
    if (m_valid || !RST) begin
      chk("dec_pc", DEC_PC, m_pc);
      chk("dec_pc4", DEC_PC4, m_pc + 32'd4);
    end
    chk("no_rvalid_with_skid", {31'b0, dut.rvalid & dut.u_skid.valid}, 32'h0);
  endtask

  task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
    @(negedge CLK);
    RST = rst; STALL = stall; REDIRECT = redir; REDIRECT_PC = tgt;
    if (!rst) model_reset();
    #1;
    last_addr = IMEM_ADDR;
    last_rd   = IMEM_RD;
    compare_model();
    @(posedge CLK);
    if (rst) model_edge(stall, redir, tgt);
    #1;
  endtask

  initial begin
    RST = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    model_reset();
    repeat (3) step(0, 0, 0, 0);

    // Reset release and streaming
    step(1, 0, 0, 0);
    chk("lit_addr0", last_addr, 32'h0);
    chk("lit_valid0", {31'b0, DEC_VALID}, 32'h0);
    step(1, 0, 0, 0);
    chk("lit_addr4", last_addr, 32'h4);
    chk("lit_first_valid", {31'b0, DEC_VALID}, 32'h1);
    chk("lit_first_pc", DEC_PC, 32'h0);
    chk("lit_first_pc4", DEC_PC4, 32'h4);
    chk("lit_first_ir", DEC_IR, 32'h0000_0013);
    step(1, 0, 0, 0);
    chk("lit_addr8", last_addr, 32'h8);
    chk("lit_pc4", DEC_PC, 32'h4);
    step(1, 0, 0, 0);
    chk("lit_pc8", DEC_PC, 32'h8);

    // Stall for three cycles
    repeat (3) begin
      step(1, 1, 0, 0);
      chk("lit_stall_rd", {31'b0, last_rd}, 32'h0);
      chk("lit_stall_pc", DEC_PC, 32'h8);
      chk("lit_stall_ir", DEC_IR, 32'h0080_0013);
    end
    step(1, 0, 0, 0);
    chk("lit_resume_c", DEC_PC, 32'hC);
    step(1, 0, 0, 0);
    chk("lit_resume_10", DEC_PC, 32'h10);

    // Redirect
    step(1, 0, 1, 32'h100);
    chk("lit_redir_addr", last_addr, 32'h100);
    chk("lit_redir_bubble", {31'b0, DEC_VALID}, 32'h0);
    chk("lit_redir_nop", DEC_IR, 32'h0000_0013);
    step(1, 0, 0, 0);
    chk("lit_redir_pc", DEC_PC, 32'h100);
    chk("lit_redir_ir", DEC_IR, 32'h1000_0013);
    step(1, 0, 0, 0);
    chk("lit_redir_pc2", DEC_PC, 32'h104);

    // Redirect while stalled with skid full
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h200);
    chk("lit_skid_flush", {31'b0, DEC_VALID}, 32'h0);
    step(1, 0, 0, 0);
    chk("lit_skid_target", DEC_PC, 32'h200);

    // Address wrap and misaligned target
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("lit_wrap_addr", last_addr, 32'h0);
    chk("lit_wrap_pc", DEC_PC, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", DEC_PC4, 32'h0);
    step(1, 0, 0, 0);
    chk("lit_wrap_next", DEC_PC, 32'h0);
    step(1, 0, 1, 32'h103);
    chk("lit_mis_addr", last_addr, 32'h100);
    step(1, 0, 0, 0);
    chk("lit_mis_pc", DEC_PC, 32'h100);

    // Asynchronous reset between edges
    @(negedge CLK);
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    chk("lit_async_valid", {31'b0, DEC_VALID}, 32'h0);
    chk("lit_async_ir", DEC_IR, 32'h0000_0013);
    chk("lit_async_rd", {31'b0, IMEM_RD}, 32'h0);
    compare_model();
    @(posedge CLK);
    #1;
    step(1, 0, 0, 0);
    chk("lit_restart_addr", last_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("lit_restart_pc", DEC_PC, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_stall, r_redir;
      r_rst   = ($urandom_range(0, 199) != 0);
      r_stall = ($urandom_range(0, 9) < 3);
      r_redir = ($urandom_range(0, 9) == 0);
      step(r_rst, r_stall, r_redir, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
